axi_rst_seq: RTL and testbench

AXI_RST_SEQ -- requirements
Module: axi_rst_seq

---
 rtl/axi_rst_pkg.sv | 29 ++
 rtl/axi_rst_seq_if.sv | 37 +++
 rtl/seq_dncnt.sv | 28 ++
 rtl/axi_rst_seq.sv | 160 ++++++++++++++++
 tb/tb_axi_rst_seq.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/axi_rst_pkg.sv
// Shared definitions for the reset sequencer: state encoding and default timing constants.
package axi_rst_pkg;

    typedef enum logic [2:0] {
        RST_ALL    = 3'd0,
        PWRUP_WAIT = 3'd1,
        SDR_INIT   = 3'd2,
        SLV_REL    = 3'd3,
        RUN        = 3'd4,
        SW_RST     = 3'd5
    } seq_state_t;

    localparam int unsigned DEF_PWRUP_CYCLES = 200;
    localparam int unsigned DEF_STAGE_GAP    = 16;
    localparam int unsigned DEF_INIT_TIMEOUT = 4096;
    localparam int unsigned DEF_SWRST_CYCLES = 8;

    // Largest of the four timing parameters; sizes the shared counter.
    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/axi_rst_seq_if.sv
// Control/status bundle between the reset sequencer and the rest of the system.
interface axi_rst_seq_if;

    logic       SW_RST_REQ;
    logic       SDR_INIT_DONE;
    logic       SDR_RESETN;
    logic       AXI_S_RESETN;
    logic       AXI_M_RESETN;
    logic       SEQ_BUSY;
    logic       INIT_ERR;
    logic [2:0] SEQ_STATE;

    // Sequencer side.
    modport master (
        input  SW_RST_REQ,
        input  SDR_INIT_DONE,
        output SDR_RESETN,
        output AXI_S_RESETN,
        output AXI_M_RESETN,
        output SEQ_BUSY,
        output INIT_ERR,
        output SEQ_STATE
    );

    // System side that requests resets and consumes the reset outputs.
    modport slave (
        output SW_RST_REQ,
        output SDR_INIT_DONE,
        input  SDR_RESETN,
        input  AXI_S_RESETN,
        input  AXI_M_RESETN,
        input  SEQ_BUSY,
        input  INIT_ERR,
        input  SEQ_STATE
    );

endinterface

// File: rtl/seq_dncnt.sv
// Loadable saturating down-counter with a zero flag, shared by all timed sequencer states.
module seq_dncnt #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             i_rstn,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_cnt;

    // Load has priority over decrement; decrement stops at zero so the count never wraps.
    always_ff @(posedge clk) begin
        if (!i_rstn) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/axi_rst_seq.sv
// Power-up / software reset sequencer: releases SDRAM, AXI slave and AXI master resets in order.
module axi_rst_seq
    import axi_rst_pkg::*;
#(
    parameter int unsigned PWRUP_CYCLES = DEF_PWRUP_CYCLES,
    parameter int unsigned STAGE_GAP    = DEF_STAGE_GAP,
    parameter int unsigned INIT_TIMEOUT = DEF_INIT_TIMEOUT,
    parameter int unsigned SWRST_CYCLES = DEF_SWRST_CYCLES
) (
    input  logic          ACLK,
    input  logic          ARESETN,
    axi_rst_seq_if.master bus
);

    localparam int unsigned CNT_W =
        $clog2(max4(PWRUP_CYCLES, STAGE_GAP, INIT_TIMEOUT, SWRST_CYCLES)) + 1;

    // A state lasting N cycles is loaded with N-1 on entry and exits on the edge that sees zero.
    localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'(PWRUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_INIT  = CNT_W'(INIT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] LD_SWRST = CNT_W'(SWRST_CYCLES - 1);

    seq_state_t       r_state;
    logic             r_sdr_resetn;
    logic             r_axi_s_resetn;
    logic             r_axi_m_resetn;
    logic             r_busy;
    logic             r_init_err;

    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_dec;
    logic             w_zero;

    seq_dncnt #(
        .WIDTH (CNT_W)
    ) u_cnt (
        .clk        (ACLK),
        .i_rstn     (ARESETN),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    // Counter control: load the duration of the state being entered on each timed transition.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = '0;
        w_dec      = 1'b0;
        case (r_state)
            RST_ALL: begin
                w_load     = 1'b1;
                w_load_val = LD_PWRUP;
            end
            PWRUP_WAIT: begin
                w_dec = 1'b1;
                if (w_zero) begin
                    w_load     = 1'b1;
                    w_load_val = LD_INIT;
                end
            end
            SDR_INIT: begin
                w_dec = 1'b1;
                if (bus.SDR_INIT_DONE) begin
                    w_load     = 1'b1;
                    w_load_val = LD_GAP;
                end else if (w_zero) begin
                    w_load     = 1'b1;
                    w_load_val = LD_PWRUP;
                end
            end
            SLV_REL: begin
                w_dec = 1'b1;
            end
            RUN: begin
                if (bus.SW_RST_REQ) begin
                    w_load     = 1'b1;
                    w_load_val = LD_SWRST;
                end
            end
            SW_RST: begin
                w_dec = 1'b1;
                if (w_zero) begin
                    w_load     = 1'b1;
                    w_load_val = LD_GAP;
                end
            end
            default: ;
        endcase
    end

    // Sequencer FSM; every output flop changes on the same edge as the transition causing it.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state        <= RST_ALL;
            r_sdr_resetn   <= 1'b0;
            r_axi_s_resetn <= 1'b0;
            r_axi_m_resetn <= 1'b0;
            r_busy         <= 1'b1;
            r_init_err     <= 1'b0;
        end else begin
            case (r_state)
                RST_ALL: begin
                    r_state <= PWRUP_WAIT;
                end
                PWRUP_WAIT: begin
                    if (w_zero) begin
                        r_state      <= SDR_INIT;
                        r_sdr_resetn <= 1'b1;
                    end
                end
                SDR_INIT: begin
                    // DONE wins over a simultaneous timeout expiry.
                    if (bus.SDR_INIT_DONE) begin
                        r_state        <= SLV_REL;
                        r_axi_s_resetn <= 1'b1;
                    end else if (w_zero) begin
                        r_state      <= PWRUP_WAIT;
                        r_sdr_resetn <= 1'b0;
                        r_init_err   <= 1'b1;
                    end
                end
                SLV_REL: begin
                    if (w_zero) begin
                        r_state        <= RUN;
                        r_axi_m_resetn <= 1'b1;
                        r_busy         <= 1'b0;
                    end
                end
                RUN: begin
                    if (bus.SW_RST_REQ) begin
                        r_state        <= SW_RST;
                        r_axi_s_resetn <= 1'b0;
                        r_axi_m_resetn <= 1'b0;
                        r_busy         <= 1'b1;
                    end
                end
                SW_RST: begin
                    if (w_zero) begin
                        r_state        <= SLV_REL;
                        r_axi_s_resetn <= 1'b1;
                    end
                end
                default: begin
                    r_state <= RST_ALL;
                end
            endcase
        end
    end

    assign bus.SDR_RESETN   = r_sdr_resetn;
    assign bus.AXI_S_RESETN = r_axi_s_resetn;
    assign bus.AXI_M_RESETN = r_axi_m_resetn;
    assign bus.SEQ_BUSY     = r_busy;
    assign bus.INIT_ERR     = r_init_err;
    assign bus.SEQ_STATE    = r_state;

endmodule

// File: tb/tb_axi_rst_seq.sv
// Bench for axi_rst_seq: timestamp-based reference model plus directed timing checks.
module tb_axi_rst_seq;
    import axi_rst_pkg::*;

    localparam int P  = 10;
    localparam int SG = 4;
    localparam int TO = 50;
    localparam int SW = 3;

    logic clk;
    logic rstn;
    int   n_cmp;
    int   n_bad;

    axi_rst_seq_if bif ();

    axi_rst_seq #(
        .PWRUP_CYCLES (P),
        .STAGE_GAP    (SG),
        .INIT_TIMEOUT (TO),
        .SWRST_CYCLES (SW)
    ) dut (
        .ACLK    (clk),
        .ARESETN (rstn),
        .bus     (bif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: on each event compute the absolute edge at which the next change is due.
    seq_state_t m_state = RST_ALL;
    logic m_sdr = 1'b0, m_s = 1'b0, m_m = 1'b0, m_err = 1'b0;
    int   cyc = 0;
    int   t_sdr = -1, t_to = -1, t_mrel = -1, t_srel = -1;

    always @(posedge clk) begin
        cyc++;
        if (!rstn) begin
            m_state = RST_ALL;
            m_sdr = 1'b0; m_s = 1'b0; m_m = 1'b0; m_err = 1'b0;
        end else begin
            case (m_state)
                RST_ALL: begin
                    m_state = PWRUP_WAIT;
                    t_sdr   = cyc + P;
                end
                PWRUP_WAIT: if (cyc == t_sdr) begin
                    m_state = SDR_INIT;
                    m_sdr   = 1'b1;
                    t_to    = cyc + TO;
                end
                SDR_INIT: begin
                    if (bif.SDR_INIT_DONE) begin
                        m_state = SLV_REL;
                        m_s     = 1'b1;
                        t_mrel  = cyc + SG;
                    end else if (cyc == t_to) begin
                        m_state = PWRUP_WAIT;
                        m_sdr   = 1'b0;
                        m_err   = 1'b1;
                        t_sdr   = cyc + P;
                    end
                end
                SLV_REL: if (cyc == t_mrel) begin
                    m_state = RUN;
                    m_m     = 1'b1;
                end
                RUN: if (bif.SW_RST_REQ) begin
                    m_state = SW_RST;
                    m_s     = 1'b0;
                    m_m     = 1'b0;
                    t_srel  = cyc + SW;
                end
                SW_RST: if (cyc == t_srel) begin
                    m_state = SLV_REL;
                    m_s     = 1'b1;
                    t_mrel  = cyc + SG;
                end
                default: ;
            endcase
        end
    end

    // Every-cycle comparison of all outputs against the model, away from the active edge.
    always @(negedge clk) begin
        chk("m_sdr_resetn",   32'(bif.SDR_RESETN),   32'(m_sdr));
        chk("m_axi_s_resetn", 32'(bif.AXI_S_RESETN), 32'(m_s));
        chk("m_axi_m_resetn", 32'(bif.AXI_M_RESETN), 32'(m_m));
        chk("m_init_err",     32'(bif.INIT_ERR),     32'(m_err));
        chk("m_seq_busy",     32'(bif.SEQ_BUSY),     32'(m_state != RUN));
        chk("m_seq_state",    32'(bif.SEQ_STATE),    32'(m_state));
    end

    // Edge index relative to the most recent reset release (edge 0 = first edge with ARESETN=1).
    int e;

    task automatic to_edge(input int k);
        while (e < k) begin
            @(negedge clk);
            e++;
        end
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        @(negedge clk);
        chk("rst_sdr",   32'(bif.SDR_RESETN),   32'd0);
        chk("rst_axi_s", 32'(bif.AXI_S_RESETN), 32'd0);
        chk("rst_axi_m", 32'(bif.AXI_M_RESETN), 32'd0);
        chk("rst_err",   32'(bif.INIT_ERR),     32'd0);
        chk("rst_busy",  32'(bif.SEQ_BUSY),     32'd1);
        chk("rst_state", 32'(bif.SEQ_STATE),    32'd0);
        rstn = 1'b1;
        e    = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rstn  = 1'b0;
        bif.SW_RST_REQ    = 1'b0;
        bif.SDR_INIT_DONE = 1'b0;
        repeat (3) @(negedge clk);

        // Power-up: DONE raised 5 cycles after SDR_RESETN.
        apply_reset();
        to_edge(9);  chk("pu_sdr_e9",  32'(bif.SDR_RESETN), 32'd0);
        to_edge(10); chk("pu_sdr_e10", 32'(bif.SDR_RESETN), 32'd1);
        chk("pu_state_e10", 32'(bif.SEQ_STATE), 32'd2);
        to_edge(14); chk("pu_s_e14", 32'(bif.AXI_S_RESETN), 32'd0);
        bif.SDR_INIT_DONE = 1'b1;
        to_edge(15); chk("pu_s_e15", 32'(bif.AXI_S_RESETN), 32'd1);
        bif.SDR_INIT_DONE = 1'b0;
        to_edge(18); chk("pu_m_e18", 32'(bif.AXI_M_RESETN), 32'd0);
        chk("pu_busy_e18", 32'(bif.SEQ_BUSY), 32'd1);
        to_edge(19); chk("pu_m_e19", 32'(bif.AXI_M_RESETN), 32'd1);
        chk("pu_busy_e19", 32'(bif.SEQ_BUSY), 32'd0);

        // Software reset pulse sampled at K=26.
        to_edge(25); bif.SW_RST_REQ = 1'b1;
        to_edge(26); bif.SW_RST_REQ = 1'b0;
        chk("sw_s_k",   32'(bif.AXI_S_RESETN), 32'd0);
        chk("sw_m_k",   32'(bif.AXI_M_RESETN), 32'd0);
        chk("sw_sdr_k", 32'(bif.SDR_RESETN),   32'd1);
        to_edge(28); chk("sw_s_k2", 32'(bif.AXI_S_RESETN), 32'd0);
        to_edge(29); chk("sw_s_k3", 32'(bif.AXI_S_RESETN), 32'd1);
        to_edge(32); chk("sw_m_k6", 32'(bif.AXI_M_RESETN), 32'd0);
        to_edge(33); chk("sw_m_k7", 32'(bif.AXI_M_RESETN), 32'd1);
        chk("sw_sdr_k7", 32'(bif.SDR_RESETN), 32'd1);

        // Timeout with SW_RST_REQ ignored while in SDR_INIT.
        apply_reset();
        to_edge(30); bif.SW_RST_REQ = 1'b1;
        to_edge(31); bif.SW_RST_REQ = 1'b0;
        chk("to_swign_state", 32'(bif.SEQ_STATE), 32'd2);
        to_edge(59); chk("to_err_e59", 32'(bif.INIT_ERR), 32'd0);
        to_edge(60); chk("to_err_e60", 32'(bif.INIT_ERR), 32'd1);
        chk("to_sdr_e60", 32'(bif.SDR_RESETN), 32'd0);
        to_edge(69); chk("to_sdr_e69", 32'(bif.SDR_RESETN), 32'd0);
        to_edge(70); chk("to_sdr_e70", 32'(bif.SDR_RESETN), 32'd1);
        bif.SDR_INIT_DONE = 1'b1;
        to_edge(71); chk("to_s_e71", 32'(bif.AXI_S_RESETN), 32'd1);
        bif.SDR_INIT_DONE = 1'b0;
        to_edge(75); chk("to_m_e75", 32'(bif.AXI_M_RESETN), 32'd1);
        chk("to_err_sticky", 32'(bif.INIT_ERR), 32'd1);

        // DONE on the timeout-expiry edge wins; then a held SW_RST_REQ retriggers in RUN.
        apply_reset();
        to_edge(59); bif.SDR_INIT_DONE = 1'b1;
        to_edge(60); bif.SDR_INIT_DONE = 1'b0;
        chk("col_s_e60",   32'(bif.AXI_S_RESETN), 32'd1);
        chk("col_err_e60", 32'(bif.INIT_ERR),     32'd0);
        chk("col_state",   32'(bif.SEQ_STATE),    32'd3);
        to_edge(62); bif.SW_RST_REQ = 1'b1;
        to_edge(64); chk("hold_m_e64", 32'(bif.AXI_M_RESETN), 32'd1);
        to_edge(65); chk("hold_m_e65", 32'(bif.AXI_M_RESETN), 32'd0);
        chk("hold_state_e65", 32'(bif.SEQ_STATE), 32'd5);
        bif.SW_RST_REQ = 1'b0;
        to_edge(68); chk("hold_s_e68", 32'(bif.AXI_S_RESETN), 32'd1);
        to_edge(72); chk("hold_m_e72", 32'(bif.AXI_M_RESETN), 32'd1);

        // Already-high DONE, then reset asserted mid-sequence in SLV_REL.
        bif.SDR_INIT_DONE = 1'b1;
        apply_reset();
        to_edge(11); chk("mid_s_e11", 32'(bif.AXI_S_RESETN), 32'd1);
        chk("mid_state_e11", 32'(bif.SEQ_STATE), 32'd3);
        bif.SDR_INIT_DONE = 1'b0;
        apply_reset();
        to_edge(10); chk("re_sdr_e10", 32'(bif.SDR_RESETN), 32'd1);
        to_edge(12); bif.SDR_INIT_DONE = 1'b1;
        to_edge(13); chk("re_s_e13", 32'(bif.AXI_S_RESETN), 32'd1);
        bif.SDR_INIT_DONE = 1'b0;
        to_edge(16); chk("re_m_e16", 32'(bif.AXI_M_RESETN), 32'd0);
        to_edge(17); chk("re_m_e17", 32'(bif.AXI_M_RESETN), 32'd1);
        chk("re_busy_e17", 32'(bif.SEQ_BUSY), 32'd0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
